mem_request_server: RTL and testbench

- Memory-side responder for the two data-memory initiators in the out-of-order core:
  - the load unit, which issues speculative reads;
  - the reorder buffer, which issues in-order store commits.
- Accepts one request at a time through a valid/accept handshake.
- Models a single-port 32-bit data array with a fixed multi-cycle access latency.
- Returns load data tagged with its ROB number, ready for the load CDB, and pulses a completion strobe back to the ROB for each store.

---
 rtl/mem_request_server_pkg.sv | 53 +++++
 rtl/mem_request_server_array.sv | 24 ++
 rtl/mem_request_server.sv | 181 ++++++++++++++++++
 tb/tb_mem_request_server.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_request_server_pkg.sv
// Shared encodings, FSM state type and lane helpers for the data-memory responder.
// The lane-extract function is also used by the load unit.
package mem_request_server_pkg;

  typedef enum logic [2:0] {
    LoadW  = 3'd0,
    LoadH  = 3'd1,
    LoadHu = 3'd2,
    LoadB  = 3'd3,
    LoadBu = 3'd4
  } ld_type_e;

  typedef enum logic [1:0] {
    StoreW = 2'd0,
    StoreH = 2'd1,
    StoreB = 2'd2
  } st_type_e;

  typedef enum logic [1:0] {
    StIdle,
    StLoadWait,
    StStoreWait
  } state_e;

  function automatic logic misaligned(input logic [1:0] off, input logic is_word,
                                      input logic is_half);
    return (is_word && (off != 2'b00)) || (is_half && off[0]);
  endfunction

  // Clears the low offset bits that the access size cannot use.
  function automatic logic [1:0] align_off(input logic [1:0] off, input logic is_word,
                                           input logic is_half);
    if (is_word) return 2'b00;
    if (is_half) return {off[1], 1'b0};
    return off;
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] off,
                                               input ld_type_e typ);
    logic [15:0] h;
    logic [7:0]  b;
    h = off[1] ? word[31:16] : word[15:0];
    b = 8'(word >> {off, 3'b000});
    case (typ)
      LoadH:   return {{16{h[15]}}, h};
      LoadHu:  return {16'h0000, h};
      LoadB:   return {{24{b[7]}}, b};
      LoadBu:  return {24'h000000, b};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/mem_request_server_array.sv
// DEPTH x 32 data array with per-byte write enables and a combinational read port.
module mem_array_bytewe #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AddrW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic [3:0]       we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_request_server.sv
// Single-port data-memory responder serving the load unit and the ROB store-commit path.
// One access in flight; stores win arbitration so commits never starve.
module mem_request_server
  import mem_request_server_pkg::*;
#(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned ROB_W   = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ld_req,
  input  logic [31:0]      ld_addr,
  input  logic [2:0]       ld_type,
  input  logic [ROB_W-1:0] ld_rob,
  output logic             ld_acc,
  output logic             ld_valid,
  output logic [31:0]      ld_data,
  output logic [ROB_W-1:0] ld_rob_out,
  input  logic             st_req,
  input  logic [31:0]      st_addr,
  input  logic [1:0]       st_type,
  input  logic [31:0]      st_data,
  output logic             st_acc,
  output logic             st_done,
  output logic             misalign,
  output logic             busy
);

  // DEPTH is a power of two, so slicing the index wraps addresses modulo DEPTH*4.
  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned AW   = IdxW + 2;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  ld_type_e         ld_type_q, ld_type_d;
  st_type_e         st_type_q, st_type_d;
  logic [31:0]      st_data_q, st_data_d;
  logic [ROB_W-1:0] rob_q, rob_d, rob_out_q, rob_out_d;
  logic [31:0]      ld_data_q, ld_data_d;
  logic             mis_q, mis_d;

  logic [3:0]  we;
  logic [31:0] wdata, rdata, ld_result;

  ld_type_e ld_t;
  st_type_e st_t;
  logic     ld_half, ld_byte, ld_word, st_half, st_byte, st_word;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{ld_addr[31:AW], st_addr[31:AW]};

  assign ld_t    = ld_type_e'(ld_type);
  assign st_t    = st_type_e'(st_type);
  assign ld_half = (ld_t == LoadH) || (ld_t == LoadHu);
  assign ld_byte = (ld_t == LoadB) || (ld_t == LoadBu);
  assign ld_word = !ld_half && !ld_byte;
  assign st_half = (st_t == StoreH);
  assign st_byte = (st_t == StoreB);
  assign st_word = !st_half && !st_byte;

  assign ld_result = lane_extract(rdata, addr_q[1:0], ld_type_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    ld_type_d = ld_type_q;
    st_type_d = st_type_q;
    st_data_d = st_data_q;
    rob_d     = rob_q;
    rob_out_d = rob_out_q;
    ld_data_d = ld_data_q;
    mis_d     = mis_q;
    ld_acc    = 1'b0;
    st_acc    = 1'b0;
    ld_valid  = 1'b0;
    st_done   = 1'b0;
    we        = 4'b0000;
    wdata     = st_data_q;
    // Gating on reset keeps pulses and array writes quiet while an access is being aborted.
    if (!reset) begin
      case (state_q)
        StIdle: begin
          if (st_req) begin
            st_acc    = 1'b1;
            state_d   = StStoreWait;
            cnt_d     = 4'(LATENCY - 1);
            addr_d    = {st_addr[AW-1:2], align_off(st_addr[1:0], st_word, st_half)};
            st_type_d = st_t;
            st_data_d = st_data;
            mis_d     = misaligned(st_addr[1:0], st_word, st_half);
          end else if (ld_req) begin
            ld_acc    = 1'b1;
            state_d   = StLoadWait;
            cnt_d     = 4'(LATENCY - 1);
            addr_d    = {ld_addr[AW-1:2], align_off(ld_addr[1:0], ld_word, ld_half)};
            ld_type_d = ld_t;
            rob_d     = ld_rob;
            mis_d     = misaligned(ld_addr[1:0], ld_word, ld_half);
          end
        end
        StLoadWait: begin
          if (cnt_q == 4'd0) begin
            ld_valid  = 1'b1;
            ld_data_d = ld_result;
            rob_out_d = rob_q;
            state_d   = StIdle;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        StStoreWait: begin
          if (cnt_q == 4'd0) begin
            st_done = 1'b1;
            state_d = StIdle;
            case (st_type_q)
              StoreH: begin
                we    = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata = {2{st_data_q[15:0]}};
              end
              StoreB: begin
                we    = 4'b0001 << addr_q[1:0];
                wdata = {4{st_data_q[7:0]}};
              end
              default: we = 4'b1111;
            endcase
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      ld_type_q <= LoadW;
      st_type_q <= StoreW;
      st_data_q <= 32'd0;
      rob_q     <= '0;
      rob_out_q <= '0;
      ld_data_q <= 32'd0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      ld_type_q <= ld_type_d;
      st_type_q <= st_type_d;
      st_data_q <= st_data_d;
      rob_q     <= rob_d;
      rob_out_q <= rob_out_d;
      ld_data_q <= ld_data_d;
      mis_q     <= mis_d;
    end
  end

  mem_array_bytewe #(
    .DEPTH (DEPTH),
    .AddrW (IdxW)
  ) u_array (
    .clk_i   (clock),
    .we_i    (we),
    .waddr_i (addr_q[AW-1:2]),
    .wdata_i (wdata),
    .raddr_i (addr_q[AW-1:2]),
    .rdata_o (rdata)
  );

  assign ld_data    = reset ? 32'd0 : (ld_valid ? ld_result : ld_data_q);
  assign ld_rob_out = reset ? '0 : (ld_valid ? rob_q : rob_out_q);
  assign misalign   = (ld_valid || st_done) && mis_q;
  assign busy       = !reset && (state_q != StIdle);

endmodule

// File: tb/tb_mem_request_server.sv
// Directed bench for mem_request_server with DEPTH=32, LATENCY=2, ROB_W=3.
module tb_mem_request_server;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_req, st_req;
  logic [31:0] ld_addr, st_addr, st_data;
  logic [2:0]  ld_type;
  logic [1:0]  st_type;
  logic [2:0]  ld_rob;
  logic        ld_acc, ld_valid, st_acc, st_done, misalign, busy;
  logic [31:0] ld_data;
  logic [2:0]  ld_rob_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Results captured by run_ops
  int          r_st_acc, r_st_done, r_ld_acc, r_ld_val;
  logic        r_st_mis, r_ld_mis, r_busy1;
  logic [31:0] r_ld_data;
  logic [2:0]  r_ld_rob;

  mem_request_server #(
    .DEPTH   (32),
    .LATENCY (2),
    .ROB_W   (3)
  ) dut (
    .clock      (clk),
    .reset      (reset),
    .ld_req     (ld_req),
    .ld_addr    (ld_addr),
    .ld_type    (ld_type),
    .ld_rob     (ld_rob),
    .ld_acc     (ld_acc),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_rob_out (ld_rob_out),
    .st_req     (st_req),
    .st_addr    (st_addr),
    .st_type    (st_type),
    .st_data    (st_data),
    .st_acc     (st_acc),
    .st_done    (st_done),
    .misalign   (misalign),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Called just after a rising edge; returns just after the edge following the last response.
  task automatic run_ops(input logic do_st, input logic [1:0] s_t, input logic [31:0] s_a,
                         input logic [31:0] s_d, input logic do_ld, input logic [2:0] l_t,
                         input logic [31:0] l_a, input logic [2:0] l_r);
    r_st_acc = -1; r_st_done = -1; r_ld_acc = -1; r_ld_val = -1;
    r_st_mis = 1'b0; r_ld_mis = 1'b0; r_busy1 = 1'b0;
    r_ld_data = 32'd0; r_ld_rob = 3'd0;
    st_req = do_st; st_type = s_t; st_addr = s_a; st_data = s_d;
    ld_req = do_ld; ld_type = l_t; ld_addr = l_a; ld_rob = l_r;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (st_acc) r_st_acc = cyc;
      if (ld_acc) r_ld_acc = cyc;
      if (r_st_acc >= 0 && cyc == r_st_acc + 1) r_busy1 = busy;
      if (r_st_acc < 0 && r_ld_acc >= 0 && cyc == r_ld_acc + 1) r_busy1 = busy;
      if (st_done) begin r_st_done = cyc; r_st_mis = misalign; end
      if (ld_valid) begin
        r_ld_val = cyc; r_ld_data = ld_data; r_ld_rob = ld_rob_out; r_ld_mis = misalign;
      end
      if ((!do_st || r_st_done >= 0) && (!do_ld || r_ld_val >= 0)) break;
      @(posedge clk); #1;
      if (r_st_acc >= 0) st_req = 1'b0;
      if (r_ld_acc >= 0) ld_req = 1'b0;
    end
    st_req = 1'b0; ld_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({ld_acc, ld_valid, st_acc, st_done, misalign, busy} !== 6'b0) begin
      failures++;
      $display("FAIL reset_pulses got=%b want=000000",
               {ld_acc, ld_valid, st_acc, st_done, misalign, busy});
    end
    checks++;
    if (ld_data !== 32'd0 || ld_rob_out !== 3'd0) begin
      failures++;
      $display("FAIL reset_data got=%h/%0d want=0/0", ld_data, ld_rob_out);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || ld_acc !== 1'b0 || st_acc !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got busy=%b ld_acc=%b st_acc=%b want 0", busy, ld_acc,
               st_acc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    run_ops(1'b1, 2'd0, 32'd8, 32'hDEADBEEF, 1'b0, 3'd0, 32'd0, 3'd0);
    checks++;
    if (r_st_acc < 0 || r_st_done - r_st_acc !== 2) begin
      failures++;
      $display("FAIL store_latency got acc=%0d done=%0d want done=acc+2", r_st_acc, r_st_done);
    end
    checks++;
    if (r_busy1 !== 1'b1 || r_st_mis !== 1'b0) begin
      failures++;
      $display("FAIL store_busy_mis got busy=%b mis=%b want 1/0", r_busy1, r_st_mis);
    end
    run_ops(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 3'd0, 32'd8, 3'd5);
    checks++;
    if (r_ld_acc < 0 || r_ld_val - r_ld_acc !== 2) begin
      failures++;
      $display("FAIL load_latency got acc=%0d valid=%0d want valid=acc+2", r_ld_acc, r_ld_val);
    end
    checks++;
    if (r_ld_data !== 32'hDEADBEEF || r_ld_rob !== 3'd5 || r_ld_mis !== 1'b0) begin
      failures++;
      $display("FAIL load_result got %h rob=%0d mis=%b want deadbeef rob=5 mis=0", r_ld_data,
               r_ld_rob, r_ld_mis);
    end
    #1;
    checks++;
    if (ld_valid !== 1'b0 || ld_data !== 32'hDEADBEEF || ld_rob_out !== 3'd5) begin
      failures++;
      $display("FAIL load_hold got valid=%b %h rob=%0d want 0 deadbeef 5", ld_valid, ld_data,
               ld_rob_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_subword();
    logic [2:0]  tt [6];
    logic [31:0] aa [6];
    logic [31:0] ee [6];
    tt = '{3'd3, 3'd3, 3'd4, 3'd1, 3'd2, 3'd3};
    aa = '{32'd0, 32'd3, 32'd3, 32'd2, 32'd2, 32'd1};
    ee = '{32'h00000001, 32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h0000007F};
    run_ops(1'b1, 2'd0, 32'd0, 32'h80FF7F01, 1'b0, 3'd0, 32'd0, 3'd0);
    for (int i = 0; i < 6; i++) begin
      run_ops(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, tt[i], aa[i], 3'(i));
      checks++;
      if (r_ld_data !== ee[i] || r_ld_mis !== 1'b0) begin
        failures++;
        $display("FAIL subword_%0d type=%0d addr=%0d got %h mis=%b want %h mis=0", i, tt[i],
                 aa[i], r_ld_data, r_ld_mis, ee[i]);
      end
    end
  endtask

  task automatic test_byte_enable();
    run_ops(1'b1, 2'd0, 32'd4, 32'h11223344, 1'b0, 3'd0, 32'd0, 3'd0);
    run_ops(1'b1, 2'd2, 32'd5, 32'h123456AA, 1'b0, 3'd0, 32'd0, 3'd0);
    run_ops(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 3'd0, 32'd4, 3'd1);
    checks++;
    if (r_ld_data !== 32'h1122AA44) begin
      failures++;
      $display("FAIL sb_lane got %h want 1122aa44", r_ld_data);
    end
    run_ops(1'b1, 2'd1, 32'd6, 32'h7777BEEF, 1'b0, 3'd0, 32'd0, 3'd0);
    run_ops(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 3'd0, 32'd4, 3'd2);
    checks++;
    if (r_ld_data !== 32'hBEEFAA44) begin
      failures++;
      $display("FAIL sh_lane got %h want beefaa44", r_ld_data);
    end
  endtask

  task automatic test_simultaneous();
    run_ops(1'b1, 2'd0, 32'd12, 32'hCAFEF00D, 1'b1, 3'd0, 32'd12, 3'd3);
    checks++;
    if (r_st_acc < 0 || r_st_done - r_st_acc !== 2) begin
      failures++;
      $display("FAIL simul_store got acc=%0d done=%0d want done=acc+2", r_st_acc, r_st_done);
    end
    checks++;
    if (r_st_done < 0 || r_ld_acc !== r_st_done + 1 || r_ld_val !== r_ld_acc + 2) begin
      failures++;
      $display("FAIL simul_order got st_done=%0d ld_acc=%0d ld_valid=%0d want ld_acc=st_done+1",
               r_st_done, r_ld_acc, r_ld_val);
    end
    checks++;
    if (r_ld_data !== 32'hCAFEF00D || r_ld_rob !== 3'd3) begin
      failures++;
      $display("FAIL simul_data got %h rob=%0d want cafef00d rob=3", r_ld_data, r_ld_rob);
    end
  endtask

  task automatic test_reset_mid_store();
    int  acc_c;
    logic seen_done;
    run_ops(1'b1, 2'd0, 32'd16, 32'h01020304, 1'b0, 3'd0, 32'd0, 3'd0);
    acc_c = -1;
    seen_done = 1'b0;
    st_req = 1'b1; st_type = 2'd0; st_addr = 32'd16; st_data = 32'hFFFFFFFF;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (st_acc) begin acc_c = cyc; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (acc_c < 0) begin
      failures++;
      $display("FAIL midreset_acc got no st_acc want st_acc");
    end
    @(posedge clk); #1;
    st_req = 1'b0;
    reset = 1'b1;
    #1;
    if (st_done) seen_done = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_busy got %b want 0", busy);
    end
    for (int i = 0; i < 3; i++) begin
      if (st_done) seen_done = 1'b1;
      @(posedge clk); #2;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      failures++;
      $display("FAIL midreset_done got st_done=1 want none");
    end
    @(posedge clk); #1;
    run_ops(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 3'd0, 32'd16, 3'd4);
    checks++;
    if (r_ld_data !== 32'h01020304) begin
      failures++;
      $display("FAIL midreset_word got %h want 01020304", r_ld_data);
    end
  endtask

  task automatic test_misalign_wrap();
    run_ops(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 3'd0, 32'h81, 3'd6);
    checks++;
    if (r_ld_data !== 32'h80FF7F01 || r_ld_mis !== 1'b1 || r_ld_rob !== 3'd6) begin
      failures++;
      $display("FAIL lw_0x81 got %h mis=%b rob=%0d want 80ff7f01 mis=1 rob=6", r_ld_data,
               r_ld_mis, r_ld_rob);
    end
    run_ops(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 3'd0, 32'h80, 3'd7);
    checks++;
    if (r_ld_data !== 32'h80FF7F01 || r_ld_mis !== 1'b0) begin
      failures++;
      $display("FAIL lw_0x80 got %h mis=%b want 80ff7f01 mis=0", r_ld_data, r_ld_mis);
    end
    run_ops(1'b1, 2'd0, 32'h44, 32'h00000000, 1'b0, 3'd0, 32'd0, 3'd0);
    run_ops(1'b1, 2'd1, 32'h47, 32'h00005555, 1'b0, 3'd0, 32'd0, 3'd0);
    checks++;
    if (r_st_mis !== 1'b1) begin
      failures++;
      $display("FAIL sh_mis got %b want 1", r_st_mis);
    end
    run_ops(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 3'd2, 32'h46, 3'd1);
    checks++;
    if (r_ld_data !== 32'h00005555 || r_ld_mis !== 1'b0) begin
      failures++;
      $display("FAIL sh_mis_word got %h mis=%b want 00005555 mis=0", r_ld_data, r_ld_mis);
    end
  endtask

  initial begin
    reset = 1'b1;
    ld_req = 1'b0; st_req = 1'b0;
    ld_addr = 32'd0; ld_type = 3'd0; ld_rob = 3'd0;
    st_addr = 32'd0; st_type = 2'd0; st_data = 32'd0;
    test_reset();
    test_store_load();
    test_subword();
    test_byte_enable();
    test_simultaneous();
    test_reset_mid_store();
    test_misalign_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
